// File: rtl/seq_div_8by4_if.sv
// seq_div_8by4_if
//   Operand/result bundle for the 8-by-4 sequential divider.
//   master : drives START, N, D; observes Q, R, READY, BUSY, DIVZ
//   slave  : the divider side of the same signals
interface seq_div_8by4_if #(
    parameter int NW = 8,
    parameter int DW = 4
);
    logic          START;
    logic [NW-1:0] N;
    logic [DW-1:0] D;
    logic [NW-1:0] Q;
    logic [DW-1:0] R;
    logic          READY;
    logic          BUSY;
    logic          DIVZ;

    modport master (
        output START, N, D,
        input  Q, R, READY, BUSY, DIVZ
    );

    modport slave (
        input  START, N, D,
        output Q, R, READY, BUSY, DIVZ
    );
endinterface

// File: rtl/seq_div_8by4.sv
// seq_div_8by4
//   Sequential restoring divider: 8-bit dividend / 4-bit divisor, producing an
//   8-bit quotient and 4-bit remainder, one quotient bit per clock.
//   Ports:
//     clock  : rising-edge clock
//     resetn : synchronous active-low reset
//     bus    : seq_div_8by4_if.slave (START, N, D in; Q, R, READY, BUSY, DIVZ out)
//   Optional feature, macro SEQ_DIV_DIVZERO_CHK_EN:
//     defined   - a zero divisor skips RUN, result Q=FF, R=F, DIVZ=1 one cycle later
//     undefined - no detection, DIVZ tied low, D==0 runs the normal 8 iterations
//
//   state  | meaning
//   IDLE   | waiting for START after reset
//   RUN    | resolving quotient bits, one per clock
//   DONE   | result valid on Q/R, START accepted for the next division
module seq_div_8by4 #(
    parameter int NW = 8,
    parameter int DW = 4
) (
    input  logic          clock,
    input  logic          resetn,
    seq_div_8by4_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] nsh_q,   nsh_d;
    // The stored partial remainder is always < divisor, so 4 bits hold it;
    // only the pre-subtract value (trial) needs the fifth bit.
    logic [DW-1:0] rem_q,   rem_d;
    logic [DW-1:0] dsr_q,   dsr_d;
    logic [NW-1:0] qacc_q,  qacc_d;
    logic [2:0]    cnt_q,   cnt_d;
    logic [NW-1:0] q_q,     q_d;
    logic [DW-1:0] r_q,     r_d;
`ifdef SEQ_DIV_DIVZERO_CHK_EN
    logic          divz_q,  divz_d;
`endif

    logic [DW:0]   trial;
    logic [DW:0]   trial_sub;
    logic          qbit;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            nsh_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef SEQ_DIV_DIVZERO_CHK_EN
            divz_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            nsh_q   <= nsh_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            qacc_q  <= qacc_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
`ifdef SEQ_DIV_DIVZERO_CHK_EN
            divz_q  <= divz_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        nsh_d     = nsh_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        qacc_d    = qacc_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        r_d       = r_q;
`ifdef SEQ_DIV_DIVZERO_CHK_EN
        divz_d    = divz_q;
`endif
        trial     = {rem_q, nsh_q[NW-1]};
        trial_sub = trial - {1'b0, dsr_q};
        qbit      = (trial >= {1'b0, dsr_q});

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.START) begin
                    nsh_d   = bus.N;
                    dsr_d   = bus.D;
                    rem_d   = '0;
                    qacc_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SEQ_DIV_DIVZERO_CHK_EN
                    divz_d  = 1'b0;
                    if (bus.D == '0) begin
                        q_d     = '1;
                        r_d     = '1;
                        divz_d  = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                rem_d  = qbit ? trial_sub[DW-1:0] : trial[DW-1:0];
                qacc_d = {qacc_q[NW-2:0], qbit};
                nsh_d  = {nsh_q[NW-2:0], 1'b0};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    q_d     = {qacc_q[NW-2:0], qbit};
                    r_d     = rem_d;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.Q     = q_q;
    assign bus.R     = r_q;
    assign bus.READY = (state_q == S_DONE);
    assign bus.BUSY  = (state_q == S_RUN);
`ifdef SEQ_DIV_DIVZERO_CHK_EN
    assign bus.DIVZ  = divz_q;
`else
    assign bus.DIVZ  = 1'b0;
`endif
endmodule

// File: tb/tb_seq_div_8by4.sv
module tb_seq_div_8by4;
    logic clock  = 1'b0;
    logic resetn = 1'b0;

    seq_div_8by4_if #(.NW(8), .DW(4)) bus ();

    seq_div_8by4 #(.NW(8), .DW(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       divz;
        int         start_edge;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected result on every READY rising edge.
    logic rdy_prev = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            rdy_prev = 1'b0;
            busy_cnt = 0;
        end else begin
            if (bus.BUSY) busy_cnt = busy_cnt + 1;
            if (bus.READY && !rdy_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("Q",       int'(bus.Q),    int'(e.q));
                    chk("R",       int'(bus.R),    int'(e.r));
                    chk("DIVZ",    int'(bus.DIVZ), int'(e.divz));
                    chk("latency", cyc - e.start_edge, e.lat);
                    chk("busy_cycles", busy_cnt, (e.lat == 8) ? 8 : 0);
                end
                busy_cnt = 0;
            end
            rdy_prev = bus.READY;
        end
    end

    // Called at a negedge; START is sampled at the next posedge.
    task automatic issue(input logic [7:0] n, input logic [3:0] d,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic ez, input int lat);
        exp_t e;
        e.q = eq; e.r = er; e.divz = ez; e.start_edge = cyc + 1; e.lat = lat;
        sb.push_back(e);
        bus.N     = n;
        bus.D     = d;
        bus.START = 1'b1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() != 0) begin
            chk("timeout_waiting_ready", 0, 1);
            sb.delete();
        end
    endtask

    task automatic op(input logic [7:0] n, input logic [3:0] d,
                      input logic [7:0] eq, input logic [3:0] er,
                      input logic ez, input int lat);
        issue(n, d, eq, er, ez, lat);
        @(negedge clock);
        bus.START = 1'b0;
        wait_done();
    endtask

    initial begin
        int low;
        int k;
        bus.START = 1'b0;
        bus.N     = '0;
        bus.D     = '0;

        // Reset state
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        chk("rst_Q",     int'(bus.Q),     0);
        chk("rst_R",     int'(bus.R),     0);
        chk("rst_READY", int'(bus.READY), 0);
        chk("rst_BUSY",  int'(bus.BUSY),  0);
        chk("rst_DIVZ",  int'(bus.DIVZ),  0);
        @(negedge clock);

        // 200 / 7
        op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);

        // 255 / 15 then back-to-back 9 / 10 with START asserted in DONE
        issue(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
        @(negedge clock);
        bus.START = 1'b0;
        wait_done();
        chk("b2b_ready_before", int'(bus.READY), 1);
        issue(8'd9, 4'd10, 8'd0, 4'd9, 1'b0, 8);
        @(negedge clock);
        bus.START = 1'b0;
        low = 0;
        k = 0;
        while (!bus.READY && k < 40) begin
            low++;
            @(negedge clock);
            k++;
        end
        chk("b2b_ready_low_cycles", low, 8);
        wait_done();

        // D = 1
        op(8'd0,   4'd1, 8'd0,   4'd0, 1'b0, 8);
        op(8'd113, 4'd1, 8'd113, 4'd0, 1'b0, 8);

        // D = 0
`ifdef SEQ_DIV_DIVZERO_CHK_EN
        op(8'd77, 4'd0, 8'hFF, 4'hF, 1'b1, 1);
`else
        op(8'd77, 4'd0, 8'hFF, 4'hD, 1'b0, 8);
`endif

        // Reset in the middle of RUN discards the operation
        bus.N = 8'd200; bus.D = 4'd7; bus.START = 1'b1;
        @(negedge clock);
        bus.START = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_busy_before_reset", int'(bus.BUSY), 1);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("abort_Q",     int'(bus.Q),     0);
        chk("abort_R",     int'(bus.R),     0);
        chk("abort_READY", int'(bus.READY), 0);
        chk("abort_BUSY",  int'(bus.BUSY),  0);
        chk("abort_DIVZ",  int'(bus.DIVZ),  0);
        repeat (12) @(negedge clock);
        chk("abort_no_ready", int'(bus.READY), 0);
        op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);

        // START toggling and operand changes during RUN are ignored
        issue(8'd150, 4'd9, 8'd16, 4'd6, 1'b0, 8);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bus.START = i[0];
            bus.N     = 8'(8'd37 * i + 8'd5);
            bus.D     = 4'(i + 2);
            if (i == 3) chk("Q_held_during_run", int'(bus.Q), 28);
        end
        @(negedge clock);
        bus.START = 1'b0;
        wait_done();

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
